// File: rtl/mod_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mod_uart_rx
//  Purpose  : Memory-mapped 8N1 UART receiver with a byte FIFO, sticky
//             overrun/framing flags and a registered interrupt request.
//
//  Ports    : clk    - system clock
//             rst    - synchronous active-high reset
//             de     - bus select for this module's address window
//             daddr  - byte address, bits [3:2] decoded
//                        0x0 status (R) / control (W)
//                        0x4 receive data (R, pops FIFO)
//                        0x8 flush (W)
//                        0xC reserved, reads 0
//             drw    - bus strobe, bit0 = write, bit1 = read
//             din    - write data
//             dout   - read data (combinational, 0 when de=0)
//             rxd    - asynchronous serial input, idle high
//             o_int  - interrupt request: ie & (ready | ovr | ferr)
//
//  Revision : 1.0 - initial release
// ============================================================================
module mod_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [31:0] daddr,
    input  logic [1:0]  drw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        rxd,
    output logic        o_int
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_depth   = 1 << DEPTH_LOG2;
    localparam int c_baud_w  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_cnt_w   = DEPTH_LOG2 + 1;

    // Last count value of a full bit period and of a half bit period.
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_half_last = c_baud_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_full  = c_cnt_w'(c_depth);

    // Register select decode of daddr[3:2]
    localparam logic [1:0] c_reg_status = 2'b00;
    localparam logic [1:0] c_reg_data   = 2'b01;
    localparam logic [1:0] c_reg_flush  = 2'b10;

    // ------------------------------------------------------------------------
    // Receive state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_baud_w-1:0]    r_baud_cnt;
    logic [c_baud_w-1:0]    w_baud_next;
    logic [2:0]             r_bit_cnt;
    logic [2:0]             w_bit_next;
    logic [7:0]             r_shift;
    logic [7:0]             w_shift_next;
    logic                   w_frame_ok;
    logic                   w_frame_err;

    // ------------------------------------------------------------------------
    // Input synchronizer. r_rxd_prev holds the previous synchronized value so
    // the idle state can detect the falling edge of a start bit.
    // ------------------------------------------------------------------------
    logic r_rxd_meta;
    logic r_rxd_sync;
    logic r_rxd_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO state and bus decode
    // ------------------------------------------------------------------------
    logic [7:0]             r_mem [c_depth];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_flush;
    logic                   w_ctrl_wr;
    logic                   w_push_ok;
    logic                   w_push_drop;
    logic [DEPTH_LOG2-1:0]  w_wr_addr;

    logic r_ovr;
    logic r_ferr;
    logic r_ie;
    logic r_int;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_full);

    assign w_pop     = de && drw[1] && (daddr[3:2] == c_reg_data) && !w_empty;
    assign w_flush   = de && drw[0] && (daddr[3:2] == c_reg_flush);
    assign w_ctrl_wr = de && drw[0] && (daddr[3:2] == c_reg_status);

    // A push is accepted when there is room, when a pop frees a slot in the
    // same cycle, or when a flush empties the FIFO in the same cycle.
    assign w_push_ok   = w_frame_ok && (w_flush || !w_full || w_pop);
    assign w_push_drop = w_frame_ok && !w_push_ok;

    // A push coinciding with a flush lands in slot 0 so that it becomes the
    // sole entry after the pointers are rewound.
    assign w_wr_addr   = w_flush ? '0 : r_wr_ptr;

    // ------------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM: next state and frame outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_frame_ok   = 1'b0;
        w_frame_err  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                if (r_rxd_prev && !r_rxd_sync) begin
                    w_state_next = ST_START;
                end
            end

            // Half a bit into the start bit: a line that is high again was a
            // glitch, not a start bit.
            ST_START: begin
                if (r_baud_cnt == c_half_last) begin
                    w_baud_next  = '0;
                    w_state_next = r_rxd_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end

            // From here every sample falls one full bit later, i.e. at the
            // centre of each data bit. Bits arrive LSB first, so shift right.
            ST_DATA: begin
                if (r_baud_cnt == c_baud_last) begin
                    w_baud_next  = '0;
                    w_shift_next = {r_rxd_sync, r_shift[7:1]};
                    w_bit_next   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end

            // Leaving at the stop-bit centre leaves half a bit of margin to
            // catch the falling edge of a back-to-back start bit.
            ST_STOP: begin
                if (r_baud_cnt == c_baud_last) begin
                    w_baud_next  = '0;
                    w_state_next = ST_IDLE;
                    if (r_rxd_sync) begin
                        w_frame_ok = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO storage (not reset; contents are invisible while count is 0)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[w_wr_addr] <= r_shift;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= DEPTH_LOG2'(w_push_ok);
            r_count  <= c_cnt_w'(w_push_ok);
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky flags, interrupt enable and registered interrupt.
    // A new error event wins over a simultaneous write-1-to-clear so that
    // no event is lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_ie   <= 1'b0;
            r_int  <= 1'b0;
        end else begin
            r_ovr  <= (r_ovr  && !(w_ctrl_wr && din[2])) || w_push_drop;
            r_ferr <= (r_ferr && !(w_ctrl_wr && din[3])) || w_frame_err;
            if (w_ctrl_wr) begin
                r_ie <= din[4];
            end
            r_int  <= r_ie && (!w_empty || r_ovr || r_ferr);
        end
    end

    assign o_int = r_int;

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    logic [31:0] w_status;
    logic [7:0]  w_head;

    always_comb begin
        w_status                   = '0;
        w_status[0]                = !w_empty;
        w_status[1]                = w_full;
        w_status[2]                = r_ovr;
        w_status[3]                = r_ferr;
        w_status[4]                = r_ie;
        w_status[8 +: c_cnt_w]     = r_count;
    end

    assign w_head = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_comb begin
        dout = '0;
        if (de) begin
            case (daddr[3:2])
                c_reg_status: dout = w_status;
                c_reg_data:   dout = {24'h0, w_head};
                default:      dout = '0;
            endcase
        end
    end

    // Address and data bits outside the decoded fields are intentionally
    // ignored.
    logic w_unused;
    assign w_unused = &{1'b0, daddr[31:4], daddr[1:0], din[31:5], din[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mod_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mod_uart_rx
//  Purpose  : Self-checking bench for mod_uart_rx at CLKS_PER_BIT=16,
//             16-entry FIFO. A vector table covers single frames (good and
//             bad stop bit); hand-written sequences cover glitch reject,
//             FIFO full/overrun, push+pop when full, flush+push, interrupt
//             timing and reset during reception.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_uart_rx;

    localparam int CLKS       = 16;
    localparam int FRAME_CYCS = 10 * CLKS;

    // Cycle (counted from the start-bit drive) one cycle before the edge on
    // which the stop bit is sampled: 2 synchronizer flops + 1 edge-detect
    // cycle + half a bit in START + 8 data bits + 1 stop bit period.
    localparam int STOP_ACT_CYC = 154;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic [31:0] daddr;
    logic [1:0]  drw;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rxd;
    logic        o_int;

    int n_checks = 0;
    int n_errors = 0;
    int int_rise;

    always #5 clk = ~clk;

    mod_uart_rx #(
        .CLKS_PER_BIT (CLKS),
        .DEPTH_LOG2   (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .de    (de),
        .daddr (daddr),
        .drw   (drw),
        .din   (din),
        .dout  (dout),
        .rxd   (rxd),
        .o_int (o_int)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [31:0] exp_status;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        de    = 1'b1;
        daddr = addr;
        drw   = 2'b10;
        din   = '0;
        #1 data = dout;
        @(negedge clk);
        de    = 1'b0;
        drw   = 2'b00;
        daddr = '0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        de    = 1'b1;
        daddr = addr;
        drw   = 2'b01;
        din   = data;
        @(negedge clk);
        de    = 1'b0;
        drw   = 2'b00;
        daddr = '0;
        din   = '0;
    endtask

    // Drives one 8N1 frame on rxd, one bit per CLKS cycles. Optionally
    // issues a one-cycle bus access at act_cyc and/or a one-cycle reset at
    // abort_cyc (after which the line returns to idle). Records the first
    // cycle at which o_int is seen high in int_rise.
    task automatic send_byte(input logic [7:0] data, input logic stop,
                             input int act_cyc, input logic [31:0] act_addr,
                             input logic [1:0] act_rw, input int abort_cyc);
        logic [9:0] frame;
        frame    = {stop, data, 1'b0};
        int_rise = -1;
        for (int c = 0; c < FRAME_CYCS + 8; c++) begin
            @(negedge clk);
            if (o_int && int_rise < 0) int_rise = c;
            de  = 1'b0;
            drw = 2'b00;
            rst = 1'b0;
            if (c == act_cyc) begin
                de    = 1'b1;
                daddr = act_addr;
                drw   = act_rw;
            end
            if (c == abort_cyc) rst = 1'b1;
            if (abort_cyc >= 0 && c >= abort_cyc) rxd = 1'b1;
            else if (c < FRAME_CYCS)              rxd = frame[c / CLKS];
            else                                  rxd = 1'b1;
        end
    endtask

    task automatic send_plain(input logic [7:0] data);
        send_byte(data, 1'b1, -1, 32'h0, 2'b00, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        vecs[0] = '{8'hA5, 1'b1, 32'h0000_0101, 32'h0000_00A5};
        vecs[1] = '{8'h3C, 1'b0, 32'h0000_0008, 32'h0000_0000};
        vecs[2] = '{8'h55, 1'b1, 32'h0000_0101, 32'h0000_0055};
        vecs[3] = '{8'h00, 1'b1, 32'h0000_0101, 32'h0000_0000};
        vecs[4] = '{8'hFF, 1'b1, 32'h0000_0101, 32'h0000_00FF};
        vecs[5] = '{8'h81, 1'b1, 32'h0000_0101, 32'h0000_0081};
        vecs[6] = '{8'hC3, 1'b0, 32'h0000_0008, 32'h0000_0000};

        rst = 1'b1; de = 1'b0; daddr = '0; drw = 2'b00; din = '0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_int", 32'(o_int), 32'h0);
        check("reset_dout_de0", dout, 32'h0);
        bus_read(32'h0, rd);
        check("reset_status", rd, 32'h0);

        // Table-driven single frames
        foreach (vecs[i]) begin
            send_byte(vecs[i].data, vecs[i].stop, -1, 32'h0, 2'b00, -1);
            bus_read(32'h0, rd);
            check($sformatf("vec%0d_status", i), rd, vecs[i].exp_status);
            bus_read(32'h4, rd);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            bus_write(32'h0, 32'h0000_000C);
            bus_read(32'h0, rd);
            check($sformatf("vec%0d_status_after", i), rd, 32'h0);
        end

        // Short low glitch is rejected; receiver still takes a real frame
        @(negedge clk);
        rxd = 1'b0;
        repeat (CLKS / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        bus_read(32'h0, rd);
        check("glitch_status", rd, 32'h0);
        send_plain(8'hA5);
        bus_read(32'h0, rd);
        check("post_glitch_status", rd, 32'h0000_0101);
        bus_read(32'h4, rd);
        check("post_glitch_data", rd, 32'h0000_00A5);

        // Fill past full: 17 bytes, last one dropped
        for (int i = 0; i <= 16; i++) send_plain(8'(i));
        bus_read(32'h0, rd);
        check("full_ovr_status", rd, 32'h0000_1007);
        bus_write(32'h0, 32'h0000_0004);
        bus_read(32'h0, rd);
        check("full_ovr_cleared", rd, 32'h0000_1003);
        // Push coinciding with a pop while full: count holds, no overrun
        send_byte(8'hEE, 1'b1, STOP_ACT_CYC, 32'h4, 2'b10, -1);
        bus_read(32'h0, rd);
        check("full_push_pop_status", rd, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            bus_read(32'h4, rd);
            check($sformatf("drain%0d", i), rd,
                  (i < 15) ? 32'(i + 1) : 32'h0000_00EE);
        end
        bus_read(32'h0, rd);
        check("drained_status", rd, 32'h0);

        // Flush coinciding with a push leaves only the new byte
        send_plain(8'h11);
        send_plain(8'h22);
        bus_read(32'h0, rd);
        check("two_bytes_status", rd, 32'h0000_0201);
        bus_read(32'hC, rd);
        check("reserved_read", rd, 32'h0);
        @(negedge clk);
        #1 check("dout_de0_nonempty", dout, 32'h0);
        send_byte(8'h33, 1'b1, STOP_ACT_CYC, 32'h8, 2'b01, -1);
        bus_read(32'h0, rd);
        check("flush_push_status", rd, 32'h0000_0101);
        bus_read(32'h4, rd);
        check("flush_push_data", rd, 32'h0000_0033);

        // Interrupt: rises shortly after the stop-bit sample, falls after pop
        bus_write(32'h0, 32'h0000_0010);
        bus_read(32'h0, rd);
        check("ie_status", rd, 32'h0000_0010);
        send_plain(8'h55);
        check("int_rise_window", 32'(int_rise >= 152 && int_rise <= 158), 32'h1);
        check("int_high", 32'(o_int), 32'h1);
        bus_read(32'h4, rd);
        check("int_data", rd, 32'h0000_0055);
        @(negedge clk);
        check("int_low_after_pop", 32'(o_int), 32'h0);
        bus_write(32'h0, 32'h0000_0000);

        // Reset in the middle of the data bits abandons the frame
        send_byte(8'h81, 1'b1, -1, 32'h0, 2'b00, 70);
        bus_read(32'h0, rd);
        check("abort_status", rd, 32'h0);
        send_plain(8'h81);
        bus_read(32'h0, rd);
        check("after_abort_status", rd, 32'h0000_0101);
        bus_read(32'h4, rd);
        check("after_abort_data", rd, 32'h0000_0081);
        bus_read(32'h0, rd);
        check("after_abort_empty", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
